// File: rtl/bru_pkg.sv
// bru_pkg: shared defaults, flag indices and interrupt-depth selection (BRU_NESTED_INT_EN)
package bru_pkg;
   localparam int ADDR_W_DEF = 16;
   localparam int FLAG_W_DEF = 3;
   localparam int FLAG_P     = 2;
   localparam int FLAG_N     = 1;
   localparam int FLAG_Z     = 0;
`ifdef BRU_NESTED_INT_EN
   localparam bit NESTED_INT_EN = 1'b1;
`else
   localparam bit NESTED_INT_EN = 1'b0;
`endif
   // Without nesting only one interrupt PC is ever saved.
   function automatic int int_depth_eff(input int depth);
      return NESTED_INT_EN ? depth : 1;
   endfunction
endpackage

// File: rtl/lifo_stack.sv
// lifo_stack: circular LIFO with top-of-stack read, saturating count and overwrite-oldest on full
module lifo_stack #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [WIDTH-1:0]           i_data,
   output logic [WIDTH-1:0]           o_top,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_full,
   output logic                       o_empty
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wp;
   logic [CW-1:0]    r_cnt;
   logic [PW-1:0]    w_wp_inc;
   logic [PW-1:0]    w_wp_dec;
   // Write pointer neighbours, wrapping modulo DEPTH; top sits just below the write pointer.
   always_comb begin
      w_wp_inc = (r_wp == PW'(DEPTH-1)) ? '0 : r_wp + PW'(1);
      w_wp_dec = (r_wp == '0) ? PW'(DEPTH-1) : r_wp - PW'(1);
      o_top    = r_mem[w_wp_dec];
      o_count  = r_cnt;
      o_full   = (r_cnt == CW'(DEPTH));
      o_empty  = (r_cnt == '0);
   end
   // Pointer and count; push wins over pop, a full push overwrites the oldest entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp  <= '0;
         r_cnt <= '0;
      end else if (i_push) begin
         r_wp  <= w_wp_inc;
         r_cnt <= o_full ? r_cnt : r_cnt + CW'(1);
      end else if (i_pop && !o_empty) begin
         r_wp  <= w_wp_dec;
         r_cnt <= r_cnt - CW'(1);
      end
   end
   // Storage is not reset and not cleared on pop.
   always_ff @(posedge clk) begin
      if (i_push && !rst) r_mem[r_wp] <= i_data;
   end
endmodule

// File: rtl/branch_ctrl_unit.sv
// branch_ctrl_unit: flag-conditioned branches, return-address stack and interrupt PC stack (BRU_NESTED_INT_EN enables nesting)
module branch_ctrl_unit
   import bru_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int FLAG_W    = FLAG_W_DEF,
   parameter int RAS_DEPTH = 8,
   parameter int INT_DEPTH = 4
) (
   input  logic                                           clk,
   input  logic                                           rst,
   input  logic [ADDR_W-1:0]                              i_pc,
   input  logic [ADDR_W-1:0]                              i_target,
   input  logic                                           i_br,
   input  logic                                           i_call,
   input  logic                                           i_ret,
   input  logic [FLAG_W-1:0]                              i_cond,
   input  logic                                           i_flag_we,
   input  logic [FLAG_W-1:0]                              i_flags_in,
   input  logic                                           i_int_in,
   input  logic                                           i_err_clr,
   output logic [ADDR_W-1:0]                              o_branch_addr,
   output logic                                           o_branch_taken,
   output logic                                           o_int_ack,
   output logic                                           o_int_state,
   output logic [$clog2(int_depth_eff(INT_DEPTH)+1)-1:0]  o_int_level,
   output logic [$clog2(RAS_DEPTH+1)-1:0]                 o_ras_count,
   output logic                                           o_ras_ovf,
   output logic                                           o_ras_unf
);
   localparam int INT_EFF = int_depth_eff(INT_DEPTH);
   logic [FLAG_W-1:0] r_flags;
   logic              r_ovf;
   logic              r_unf;
   logic [ADDR_W-1:0] w_int_top;
   logic [ADDR_W-1:0] w_ras_top;
   logic              w_int_full;
   logic              w_int_empty;
   logic              w_ras_full;
   logic              w_ras_empty;
   logic              w_ret_act;
   logic              w_int_pop;
   logic              w_ras_push;
   logic              w_ras_pop;
   logic              w_ovf_ev;
   logic              w_unf_ev;
   // An accepted interrupt suppresses br/call/ret for the cycle; ret drains interrupt PCs before the RAS.
   always_comb begin
      o_int_ack      = i_int_in & ~w_int_full;
      w_ret_act      = i_ret & ~o_int_ack;
      o_branch_taken = ~o_int_ack & ((i_br & |(i_cond & r_flags)) | i_ret);
      w_int_pop      = w_ret_act & ~w_int_empty;
      w_ras_pop      = w_ret_act & w_int_empty & ~w_ras_empty;
      w_unf_ev       = w_ret_act & w_int_empty & w_ras_empty;
      w_ras_push     = o_branch_taken & i_call & ~i_ret;
      w_ovf_ev       = w_ras_push & w_ras_full;
      o_branch_addr  = ~w_ret_act ? i_target : ~w_int_empty ? w_int_top : ~w_ras_empty ? w_ras_top : '0;
      o_int_state    = ~w_int_empty;
      o_ras_ovf      = r_ovf;
      o_ras_unf      = r_unf;
   end
   // Flags and sticky errors; a new error in the same cycle beats err_clr.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_flags <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         if (i_flag_we) r_flags <= i_flags_in;
         r_ovf <= w_ovf_ev ? 1'b1 : i_err_clr ? 1'b0 : r_ovf;
         r_unf <= w_unf_ev ? 1'b1 : i_err_clr ? 1'b0 : r_unf;
      end
   end
   lifo_stack #(.WIDTH(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_ras_push),
      .i_pop   (w_ras_pop),
      .i_data  (ADDR_W'(i_pc + ADDR_W'(1))),
      .o_top   (w_ras_top),
      .o_count (o_ras_count),
      .o_full  (w_ras_full),
      .o_empty (w_ras_empty)
   );
   lifo_stack #(.WIDTH(ADDR_W), .DEPTH(INT_EFF)) u_int (
      .clk     (clk),
      .rst     (rst),
      .i_push  (o_int_ack),
      .i_pop   (w_int_pop),
      .i_data  (i_pc),
      .o_top   (w_int_top),
      .o_count (o_int_level),
      .o_full  (w_int_full),
      .o_empty (w_int_empty)
   );
endmodule
